// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared constants and scoreboard entry type for the hazard stall unit
package hazard_stall_unit_pkg;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [3:0] TUSE_NONE = 4'hF;

    typedef struct packed {
        logic [4:0] dst;
        logic [3:0] tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{dst: REG_ZERO, tnew: 4'd0};

    // Latency ages by one per stage but never wraps below zero.
    function automatic logic [3:0] sat_dec(input logic [3:0] x);
        return (x == 4'd0) ? 4'd0 : x - 4'd1;
    endfunction

    function automatic logic stage_hit(input logic [4:0] src, input logic [3:0] tuse,
                                       input sb_entry_t s);
        return (src != REG_ZERO) && (src == s.dst) && (s.tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// rtl/hazard_stall_unit_md_busy_counter.sv - mult/div occupancy counter, reloaded on every start
module md_busy_counter #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (start) begin
            count <= is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign busy = start | (count != 4'd0);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - D-stage Tuse/Tnew hazard controller; HAZARD_MDU_BUSY_EN adds mult/div busy stalls
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_MUL_CYCLES = 5,
    parameter int MD_DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [3:0] d_tuse_rs,
    input  logic [3:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [3:0] d_tnew,
    input  logic       d_is_md,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       stall,
    output logic       pc_en,
    output logic       d_en,
    output logic       e_flush,
    output logic [4:0] e_dst,
    output logic [4:0] m_dst,
    output logic [3:0] e_tnew,
    output logic [3:0] m_tnew,
    output logic       md_busy
);

    sb_entry_t e_q;
    sb_entry_t m_q;
    logic      reg_stall;
    logic      md_stall;

    assign reg_stall = stage_hit(d_rs, d_tuse_rs, e_q) | stage_hit(d_rs, d_tuse_rs, m_q) |
                       stage_hit(d_rt, d_tuse_rt, e_q) | stage_hit(d_rt, d_tuse_rt, m_q);

`ifdef HAZARD_MDU_BUSY_EN
    md_busy_counter #(
        .MUL_CYCLES (MD_MUL_CYCLES),
        .DIV_CYCLES (MD_DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (md_is_div),
        .busy   (md_busy)
    );

    assign md_stall = d_is_md & md_busy;
`else
    // The mult/div ports stay on the boundary so both builds share one wrapper.
    logic                unused_md_inputs;
    localparam bit [3:0] unused_md_cycles = 4'(MD_MUL_CYCLES) ^ 4'(MD_DIV_CYCLES);

    assign unused_md_inputs = &{1'b0, d_is_md, md_start, md_is_div, unused_md_cycles};
    assign md_busy          = 1'b0;
    assign md_stall         = 1'b0;
`endif

    assign stall   = reg_stall | md_stall;
    assign pc_en   = ~stall;
    assign d_en    = ~stall;
    assign e_flush = stall;

    // A stalled D instruction stays put, so E receives a bubble instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= SB_EMPTY;
            m_q <= SB_EMPTY;
        end else begin
            if (stall) begin
                e_q <= SB_EMPTY;
            end else begin
                e_q <= '{dst: d_dst, tnew: sat_dec(d_tnew)};
            end
            m_q <= '{dst: e_q.dst, tnew: sat_dec(e_q.tnew)};
        end
    end

    assign e_dst  = e_q.dst;
    assign e_tnew = e_q.tnew;
    assign m_dst  = m_q.dst;
    assign m_tnew = m_q.tnew;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [3:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_is_md, md_start, md_is_div;
    logic       stall, pc_en, d_en, e_flush, md_busy;
    logic [4:0] e_dst, m_dst;
    logic [3:0] e_tnew, m_tnew;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(.MD_MUL_CYCLES(5), .MD_DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_is_md(d_is_md),
        .md_start(md_start), .md_is_div(md_is_div),
        .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_flush(e_flush),
        .e_dst(e_dst), .m_dst(m_dst), .e_tnew(e_tnew), .m_tnew(m_tnew),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic [3:0] tuse_rs, tuse_rt;
        logic [4:0] dst;
        logic [3:0] tnew;
        logic       exp_stall;
        logic [4:0] exp_e_dst;
        logic [3:0] exp_e_tnew;
        logic [4:0] exp_m_dst;
        logic [3:0] exp_m_tnew;
    } vec_t;

    typedef struct {
        logic [4:0] e_dst;
        logic [3:0] e_tnew;
        logic [4:0] m_dst;
        logic [3:0] m_tnew;
    } sb_exp_t;

    sb_exp_t exp_q[$];
    vec_t    vecs[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] tur,
                         input logic [3:0] tut, input logic [4:0] dst, input logic [3:0] tn);
        d_rs = rs; d_rt = rt; d_tuse_rs = tur; d_tuse_rt = tut; d_dst = dst; d_tnew = tn;
    endtask

    task automatic check_comb(input string tag, input logic exp_stall);
        check({tag, ".stall"}, {7'd0, stall}, {7'd0, exp_stall});
        check({tag, ".pc_en"}, {7'd0, pc_en}, {7'd0, ~exp_stall});
        check({tag, ".d_en"}, {7'd0, d_en}, {7'd0, ~exp_stall});
        check({tag, ".e_flush"}, {7'd0, e_flush}, {7'd0, exp_stall});
    endtask

    task automatic pop_and_check(input string tag);
        sb_exp_t x;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            x = exp_q.pop_front();
            check({tag, ".e_dst"}, {3'd0, e_dst}, {3'd0, x.e_dst});
            check({tag, ".e_tnew"}, {4'd0, e_tnew}, {4'd0, x.e_tnew});
            check({tag, ".m_dst"}, {3'd0, m_dst}, {3'd0, x.m_dst});
            check({tag, ".m_tnew"}, {4'd0, m_tnew}, {4'd0, x.m_tnew});
        end
    endtask

    initial begin
        int run;
        bit seen_end;
        // rs rt tuse_rs tuse_rt dst tnew | stall | E after | M after
        vecs[0]  = '{5'd0, 5'd0, 4'hF, 4'hF, 5'd8, 4'd3, 1'b0, 5'd8, 4'd2, 5'd0, 4'd0};
        vecs[1]  = '{5'd8, 5'd0, 4'd1, 4'hF, 5'd9, 4'd2, 1'b1, 5'd0, 4'd0, 5'd8, 4'd1};
        vecs[2]  = '{5'd8, 5'd0, 4'd1, 4'hF, 5'd9, 4'd2, 1'b0, 5'd9, 4'd1, 5'd0, 4'd0};
        vecs[3]  = '{5'd0, 5'd9, 4'hF, 4'd0, 5'd5, 4'd3, 1'b1, 5'd0, 4'd0, 5'd9, 4'd0};
        vecs[4]  = '{5'd0, 5'd9, 4'hF, 4'd0, 5'd5, 4'd3, 1'b0, 5'd5, 4'd2, 5'd0, 4'd0};
        vecs[5]  = '{5'd5, 5'd0, 4'hF, 4'hF, 5'd0, 4'd3, 1'b0, 5'd0, 4'd2, 5'd5, 4'd1};
        vecs[6]  = '{5'd0, 5'd0, 4'd0, 4'd0, 5'd7, 4'd0, 1'b0, 5'd7, 4'd0, 5'd0, 4'd1};
        vecs[7]  = '{5'd7, 5'd0, 4'd0, 4'hF, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd7, 4'd0};
        vecs[8]  = '{5'd7, 5'd7, 4'd0, 4'd0, 5'd3, 4'd1, 1'b0, 5'd3, 4'd0, 5'd0, 4'd0};
        vecs[9]  = '{5'd0, 5'd0, 4'hF, 4'hF, 5'd4, 4'd5, 1'b0, 5'd4, 4'd4, 5'd3, 4'd0};
        vecs[10] = '{5'd0, 5'd0, 4'hF, 4'hF, 5'd4, 4'd4, 1'b0, 5'd4, 4'd3, 5'd4, 4'd3};
        vecs[11] = '{5'd4, 5'd0, 4'd2, 4'hF, 5'd0, 4'd0, 1'b1, 5'd0, 4'd0, 5'd4, 4'd2};
        vecs[12] = '{5'd4, 5'd0, 4'd2, 4'hF, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd0, 4'd0};

        reset = 1'b1; d_is_md = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
        drive(5'd0, 5'd0, 4'hF, 4'hF, 5'd0, 4'd0);
        repeat (3) tick();
        check_comb("reset", 1'b0);
        check("reset.md_busy", {7'd0, md_busy}, 8'd0);
        exp_q.push_back('{5'd0, 4'd0, 5'd0, 4'd0});
        pop_and_check("reset");
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].tuse_rs, vecs[i].tuse_rt,
                  vecs[i].dst, vecs[i].tnew);
            exp_q.push_back('{vecs[i].exp_e_dst, vecs[i].exp_e_tnew,
                              vecs[i].exp_m_dst, vecs[i].exp_m_tnew});
            #1;
            check_comb($sformatf("vec%0d", i), vecs[i].exp_stall);
            tick();
            pop_and_check($sformatf("vec%0d", i));
        end

        // Reset while a load-use stall is in progress.
        drive(5'd0, 5'd0, 4'hF, 4'hF, 5'd8, 4'd3);
        tick();
        drive(5'd8, 5'd0, 4'd1, 4'hF, 5'd0, 4'd0);
        #1;
        check_comb("rstmid.before", 1'b1);
        reset = 1'b1;
        exp_q.push_back('{5'd0, 4'd0, 5'd0, 4'd0});
        tick();
        check_comb("rstmid.after", 1'b0);
        pop_and_check("rstmid");
        reset = 1'b0;
        drive(5'd0, 5'd0, 4'hF, 4'hF, 5'd0, 4'd0);
        tick();

`ifdef HAZARD_MDU_BUSY_EN
        // Divide start with a dependent mult/div op held in D.
        md_start = 1'b1; md_is_div = 1'b1; d_is_md = 1'b1;
        run = 0; seen_end = 1'b0;
        for (int c = 0; c < 30 && !seen_end; c++) begin
            #1;
            if (stall) run++;
            else seen_end = 1'b1;
            tick();
            md_start = 1'b0;
        end
        check("md.run_len", 8'(run), 8'd11);
        check("md.ended", {7'd0, seen_end}, 8'd1);
        check("md.busy_after", {7'd0, md_busy}, 8'd0);
        d_is_md = 1'b0;
`else
        md_start = 1'b1; md_is_div = 1'b1; d_is_md = 1'b1;
        run = 0; seen_end = 1'b0;
        #1;
        check("md_off.stall", {7'd0, stall}, 8'd0);
        check("md_off.busy", {7'd0, md_busy}, 8'd0);
        tick();
        md_start = 1'b0;
        check("md_off.stall2", {7'd0, stall}, 8'd0);
        d_is_md = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
